// File: rtl/pattern_event_logger.sv
// pattern_event_logger
// Captures a timestamp for every cycle the 101001 detector reports a match,
// queues the timestamps in a small first-word-fall-through FIFO for a readout
// stage, and keeps a saturating match counter plus a sticky overflow flag.
//
// Handshake: o_valid high means o_rd_data holds the oldest queued timestamp.
// A pop happens on a rising clk_gate edge where i_rd_en and o_valid are both
// high. i_rd_en while o_valid is low is ignored. The strobe side has no
// back-pressure: an event that arrives while the FIFO is full and not being
// popped is dropped and recorded in o_overflow.
module pattern_event_logger #(
    parameter int TS_WIDTH  = 6,
    parameter int DEPTH     = 4,
    parameter int CNT_WIDTH = 8
) (
    input  logic                       clk_gate,
    input  logic                       i_resetn,
    input  logic                       i_pattern_found,
    input  logic [TS_WIDTH-1:0]        i_timestamp,
    input  logic                       i_rd_en,
    input  logic                       i_clr_ovf,
    output logic [TS_WIDTH-1:0]        o_rd_data,
    output logic                       o_valid,
    output logic                       o_empty,
    output logic                       o_full,
    output logic [$clog2(DEPTH):0]     o_level,
    output logic                       o_overflow,
    output logic [CNT_WIDTH-1:0]       o_match_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    logic [TS_WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0]    rd_ptr;
    logic [PTR_W-1:0]    wr_ptr;
    logic [PTR_W-1:0]    rd_ptr_nxt;
    logic [PTR_W-1:0]    wr_ptr_nxt;
    logic [LVL_W-1:0]    level;
    logic [LVL_W-1:0]    level_nxt;
    logic [TS_WIDTH-1:0] head_nxt;
    logic                rd_acc;
    logic                wr_acc;
    logic                drop;

    // The level counter alone decides full and empty.
    assign o_empty = (level == '0);
    assign o_full  = (level == LVL_W'(DEPTH));
    assign o_valid = ~o_empty;
    assign o_level = level;

    // A full FIFO still takes a write when the same edge pops the head.
    assign rd_acc = i_rd_en && !o_empty;
    assign wr_acc = i_pattern_found && (!o_full || rd_acc);
    assign drop   = i_pattern_found && o_full && !rd_acc;

    // Next pointers, occupancy and the registered head value.
    always_comb begin
        rd_ptr_nxt = rd_ptr;
        wr_ptr_nxt = wr_ptr;
        level_nxt  = level;
        head_nxt   = '0;
        if (rd_acc) begin
            rd_ptr_nxt = rd_ptr + PTR_W'(1);
        end
        if (wr_acc) begin
            wr_ptr_nxt = wr_ptr + PTR_W'(1);
        end
        if (wr_acc && !rd_acc) begin
            level_nxt = level + LVL_W'(1);
        end else if (rd_acc && !wr_acc) begin
            level_nxt = level - LVL_W'(1);
        end
        // When the slot being written becomes the new head (empty FIFO, or a
        // pop of the last entry) the incoming timestamp bypasses storage.
        if (level_nxt != '0) begin
            if (wr_acc && (wr_ptr == rd_ptr_nxt)) begin
                head_nxt = i_timestamp;
            end else begin
                head_nxt = mem[rd_ptr_nxt];
            end
        end
    end

    // Timestamp storage; contents are don't-care until written.
    always_ff @(posedge clk_gate) begin
        if (wr_acc) begin
            mem[wr_ptr] <= i_timestamp;
        end
    end

    // FIFO control state and the registered output word.
    always_ff @(posedge clk_gate or negedge i_resetn) begin
        if (!i_resetn) begin
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            level     <= '0;
            o_rd_data <= '0;
        end else begin
            rd_ptr    <= rd_ptr_nxt;
            wr_ptr    <= wr_ptr_nxt;
            level     <= level_nxt;
            o_rd_data <= head_nxt;
        end
    end

    // Sticky overflow: a new drop takes priority over a clear request.
    always_ff @(posedge clk_gate or negedge i_resetn) begin
        if (!i_resetn) begin
            o_overflow <= 1'b0;
        end else if (drop) begin
            o_overflow <= 1'b1;
        end else if (i_clr_ovf) begin
            o_overflow <= 1'b0;
        end
    end

    // Total strobe count, dropped events included; holds at all-ones.
    always_ff @(posedge clk_gate or negedge i_resetn) begin
        if (!i_resetn) begin
            o_match_count <= '0;
        end else if (i_pattern_found && (o_match_count != '1)) begin
            o_match_count <= o_match_count + CNT_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_pattern_event_logger.sv
// tb_pattern_event_logger
// Table of strobe/pop/clear steps with hand-derived level, overflow and count,
// plus a timestamp queue that predicts pop order and head contents. Reset and
// counter saturation (narrow counter instance) are driven by hand.
module tb_pattern_event_logger;

    localparam int DEPTH = 4;

    logic       clk_gate = 1'b0;
    logic       i_resetn = 1'b0;

    logic       pf = 1'b0;
    logic [5:0] ts = '0;
    logic       rd = 1'b0;
    logic       clr = 1'b0;
    logic [5:0] rd_data;
    logic       valid, empty, full, ovf;
    logic [2:0] level;
    logic [7:0] count;

    logic       pf2 = 1'b0;
    logic [5:0] ts2 = '0;
    logic       rd2 = 1'b0;
    logic       clr2 = 1'b0;
    logic [5:0] rd_data2;
    logic       valid2, empty2, full2, ovf2;
    logic [2:0] level2;
    logic [2:0] count2;

    int tests = 0;
    int fails = 0;

    logic [5:0] exp_q[$];

    typedef struct {
        logic       pf;
        logic [5:0] ts;
        logic       rd;
        logic       clr;
        int         lvl;
        logic       ovf;
        int         cnt;
    } vec_t;

    vec_t vecs[$];

    always #5 clk_gate = ~clk_gate;

    pattern_event_logger #(.TS_WIDTH(6), .DEPTH(DEPTH), .CNT_WIDTH(8)) dut (
        .clk_gate(clk_gate), .i_resetn(i_resetn),
        .i_pattern_found(pf), .i_timestamp(ts), .i_rd_en(rd), .i_clr_ovf(clr),
        .o_rd_data(rd_data), .o_valid(valid), .o_empty(empty), .o_full(full),
        .o_level(level), .o_overflow(ovf), .o_match_count(count)
    );

    pattern_event_logger #(.TS_WIDTH(6), .DEPTH(DEPTH), .CNT_WIDTH(3)) dut_sat (
        .clk_gate(clk_gate), .i_resetn(i_resetn),
        .i_pattern_found(pf2), .i_timestamp(ts2), .i_rd_en(rd2), .i_clr_ovf(clr2),
        .o_rd_data(rd_data2), .o_valid(valid2), .o_empty(empty2), .o_full(full2),
        .o_level(level2), .o_overflow(ovf2), .o_match_count(count2)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic add(input logic p, input int t, input logic r, input logic c,
                       input int l, input logic o, input int n);
        vec_t v;
        v.pf = p; v.ts = 6'(t); v.rd = r; v.clr = c; v.lvl = l; v.ovf = o; v.cnt = n;
        vecs.push_back(v);
    endtask

    task automatic apply(input vec_t v);
        logic [5:0] e;
        @(negedge clk_gate);
        pf = v.pf; ts = v.ts; rd = v.rd; clr = v.clr;
        if (v.rd && (exp_q.size() > 0)) begin
            e = exp_q.pop_front();
            check("pop_data", 32'(rd_data), 32'(e));
        end
        if (v.pf && (exp_q.size() < DEPTH)) exp_q.push_back(v.ts);
        @(posedge clk_gate);
        #1;
        check("level", 32'(level), 32'(v.lvl));
        check("overflow", 32'(ovf), 32'(v.ovf));
        check("match_count", 32'(count), 32'(v.cnt));
        check("empty", 32'(empty), 32'(v.lvl == 0));
        check("valid", 32'(valid), 32'(v.lvl != 0));
        check("full", 32'(full), 32'(v.lvl == DEPTH));
        if (exp_q.size() > 0) check("head_data", 32'(rd_data), 32'(exp_q[0]));
    endtask

    task automatic idle_inputs();
        @(negedge clk_gate);
        pf = 0; rd = 0; clr = 0; ts = '0;
    endtask

    initial begin
        // single event, then pop
        add(1, 17, 0, 0, 1, 0, 1);
        add(0,  0, 0, 0, 1, 0, 1);
        add(0,  0, 1, 0, 0, 0, 1);
        // ordering and full flag
        add(1,  5, 0, 0, 1, 0, 2);
        add(1,  9, 0, 0, 2, 0, 3);
        add(1, 40, 0, 0, 3, 0, 4);
        add(1, 63, 0, 0, 4, 0, 5);
        for (int i = 3; i >= 0; i--) add(0, 0, 1, 0, i, 0, 5);
        // overflow and clear
        for (int i = 1; i <= 4; i++) add(1, i, 0, 0, i, 0, 5 + i);
        add(1, 12, 0, 0, 4, 1, 10);
        add(0,  0, 0, 0, 4, 1, 10);
        add(0,  0, 0, 1, 4, 0, 10);
        // full with simultaneous read and write, drain 2,3,4,8
        add(1,  8, 1, 0, 4, 0, 11);
        for (int i = 3; i >= 0; i--) add(0, 0, 1, 0, i, 0, 11);
        // read while empty is ignored
        add(0,  0, 1, 0, 0, 0, 11);
        // read+write on empty, then on a single entry
        add(1, 20, 1, 0, 1, 0, 12);
        add(1, 30, 1, 0, 1, 0, 13);
        add(0,  0, 1, 0, 0, 0, 13);
        // drop coinciding with clear: set wins
        for (int i = 0; i < 4; i++) add(1, 50 + i, 0, 0, i + 1, 0, 14 + i);
        add(1, 54, 0, 1, 4, 1, 18);
        add(0,  0, 0, 1, 4, 0, 18);
        for (int i = 3; i >= 0; i--) add(0, 0, 1, 0, i, 0, 18);

        // reset state
        repeat (2) @(posedge clk_gate);
        #1;
        check("rst_level", 32'(level), 32'd0);
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_valid", 32'(valid), 32'd0);
        check("rst_full", 32'(full), 32'd0);
        check("rst_ovf", 32'(ovf), 32'd0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_data", 32'(rd_data), 32'd0);
        @(negedge clk_gate);
        i_resetn = 1'b1;

        foreach (vecs[i]) apply(vecs[i]);

        // reset mid-run with three entries queued
        for (int i = 0; i < 3; i++) begin
            vec_t v;
            v.pf = 1; v.ts = 6'(7 + i); v.rd = 0; v.clr = 0;
            v.lvl = i + 1; v.ovf = 0; v.cnt = 19 + i;
            apply(v);
        end
        @(negedge clk_gate);
        pf = 0; rd = 0; clr = 0;
        #2;
        i_resetn = 1'b0;
        #1;
        exp_q.delete();
        check("midrst_level", 32'(level), 32'd0);
        check("midrst_empty", 32'(empty), 32'd1);
        check("midrst_count", 32'(count), 32'd0);
        check("midrst_ovf", 32'(ovf), 32'd0);
        check("midrst_data", 32'(rd_data), 32'd0);
        @(negedge clk_gate);
        i_resetn = 1'b1;

        // saturation on the 3-bit counter instance
        for (int i = 0; i < 10; i++) begin
            @(negedge clk_gate);
            pf2 = 1; ts2 = 6'(i); rd2 = 1;
            @(posedge clk_gate);
            #1;
            check("sat_count", 32'(count2), 32'((i + 1 > 7) ? 7 : i + 1));
            check("sat_level", 32'(level2), 32'd1);
            check("sat_head", 32'(rd_data2), 32'(i));
        end
        @(negedge clk_gate);
        pf2 = 0; rd2 = 1;
        @(posedge clk_gate);
        #1;
        check("sat_drain_level", 32'(level2), 32'd0);
        check("sat_drain_count", 32'(count2), 32'd7);
        @(negedge clk_gate);
        rd2 = 1;
        @(posedge clk_gate);
        #1;
        check("sat_emptyrd_level", 32'(level2), 32'd0);
        check("sat_emptyrd_empty", 32'(empty2), 32'd1);
        check("sat_emptyrd_count", 32'(count2), 32'd7);
        check("sat_emptyrd_ovf", 32'(ovf2), 32'd0);
        idle_inputs();
        rd2 = 0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
